seq_mult_sm: RTL
================

Name: seq_mult_sm

Overview:
Parametrised sequential shift-add multiplier, the next generation of the team's 8-bit signed multiplier datapath. It takes DW-bit operands in either two's-complement or unsigned mode and multiplies magnitudes over up to DW add/shift cycles. The sign is applied at the end and a registered 2*DW-bit product is presented. It sits between the operand-capture registers and the LED/display driver, and uses a start/ready/done handshake plus a synchronous clean (abort).

Parameters:
DW, 8, operand width in bits (>=2)
EARLY_TERM, 1, 1 = leave ADD_SHIFT as soon as the remaining multiplier is zero; 0 = always exactly DW ADD_SHIFT cycles

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  request; sampled only when ready=1
clean  in  1  synchronous abort/clear; priority over start
signed_mode  in  1  1 = operands are two's complement, 0 = unsigned; captured with start
multiplicand  in  DW  operand A; captured with start
multiplier  in  DW  operand B; captured with start
ready  out  1  high in IDLE only
done  out  1  one-cycle pulse, product valid
product  out  2*DW  result (two's complement if signed_mode, else unsigned); held until next done or clean
sign  out  1  result sign; 0 whenever product is zero

Behaviour:
- Reset (rst=0, async): state=IDLE, ready=1, done=0, product=0, sign=0, all internal registers 0.
- States: IDLE, INIT, ADD_SHIFT, DONE (state_t, 2 bits).
- IDLE: ready=1. On start=1 and clean=0: capture operands and signed_mode; go to INIT. start in any other state is ignored, with no queuing.
- INIT (1 cycle): compute magnitudes. In signed mode, |x| = x[DW-1] ? -x : x, evaluated in DW bits as unsigned, so the most negative value gives 2^(DW-1) with no overflow.
  - In unsigned mode, magnitudes equal the raw operands.
  - res_sign = signed_mode & (A[DW-1]^B[DW-1]).
  - acc=0, mltnd register = zero-extended |A| (2*DW bits), mlter = |B|, cnt=0; go to ADD_SHIFT.
- ADD_SHIFT (per cycle):
  - if mlter[0], acc += mltnd (2*DW bits, no carry out possible);
  - mltnd <<= 1; mlter >>= 1; cnt++.
  - Exit to DONE when cnt reaches DW-1 (DW iterations done), or when EARLY_TERM=1 and the post-shift mlter == 0.
  - There is always at least one ADD_SHIFT cycle.
- DONE (1 cycle): product <= res_sign ? -acc : acc; sign <= res_sign & (acc!=0); done=1; go to IDLE. ready rises the following cycle.
- Latency (start sampled at edge 0):
  - EARLY_TERM=0: done high in cycle DW+2, i.e. cycle 10 for DW=8.
  - EARLY_TERM=1: done high in cycle 2+N, with N = max(1, position of the highest set bit of |B| + 1).
  - Back-to-back: start may be asserted in the cycle after done.
- clean=1 in any state: next edge state=IDLE, acc/product/sign cleared, done=0. clean together with start in IDLE: clean wins and the start is dropped.
- Reset mid-operation: immediate return to the reset values; no done pulse.
- Width rule: |A|*|B| <= 2^(2*DW-2), so the signed result always fits in 2*DW bits, including (-2^(DW-1))^2.
- Operand inputs may change freely after the capture edge.

Decomposition:
- Shared package additions: DW; DW2 = 2*DW; CW = $clog2(DW).
- Typedefs: data_t [DW-1:0], product_t [DW2-1:0], count_t [CW:0], state_t enum {IDLE, INIT, ADD_SHIFT, DONE}.
- Control struct: {load, ready, clean, done, state}.
- One sub-module: mag_sign_conv, which is combinational: DW-bit value plus a signed_mode flag in, magnitude and sign bit out. It is instantiated twice in INIT, and its negate logic is reused for the final product negation, parametrised by width.
- The FSM and datapath stay in seq_mult_sm.

Test Plan:
1. DW=8, EARLY_TERM=0, signed: A=-5 (0xFB), B=7 -> done at cycle 10; product=0xFFDD (-35), sign=1.
2. Signed: A=-128, B=-128 -> product=0x4000 (16384), sign=0. Unsigned: A=0xFF, B=0xFF -> product=0xFE01, sign=0.
3. EARLY_TERM=1: B=0, A=0x55 -> done at cycle 3; product=0. B=3, A=9 -> done at cycle 4; product=27. B=0x80 unsigned -> done at cycle 10.
4. Signed: A=-1, B=0 -> product=0, sign=0 (no negative zero).
5. start pulsed again during ADD_SHIFT with new operands -> ignored; first result is correct. A second start in the cycle after done -> accepted, and its result follows with the nominal latency.
6. clean asserted in the 3rd ADD_SHIFT cycle -> IDLE next cycle, product=0, no done. Separately, rst low mid-op -> outputs take reset values asynchronously, and the next start computes correctly.

Source files
------------

// File: rtl/seq_mult_sm_pkg.sv
// Shared widths, FSM state encoding and the control bundle of the sequential multiplier.
package seq_mult_sm_pkg;

  localparam int DW  = 8;
  localparam int DW2 = 2 * DW;
  localparam int CW  = $clog2(DW);

  typedef logic [DW-1:0]  data_t;
  typedef logic [DW2-1:0] product_t;
  typedef logic [CW:0]    count_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INIT      = 2'd1,
    ADD_SHIFT = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Per-cycle decisions of the controller, consumed by the datapath registers.
  typedef struct packed {
    logic   load;
    logic   ready;
    logic   clean;
    logic   done;
    state_t state;
  } ctrl_t;

endpackage

// File: rtl/seq_mult_sm_mag_sign_conv.sv
// Combinational conditional negate: magnitude of a two's-complement value, or a forced negate.
// Zero latency; no handshake, purely combinational.
module mag_sign_conv #(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  logic         signed_mode,
  input  logic         neg_req,
  output logic [W-1:0] mag,
  output logic         sgn
);

  // Most negative input wraps to 2^(W-1), which is its correct unsigned magnitude.
  always_comb begin
    sgn = (signed_mode & val[W-1]) | neg_req;
    mag = sgn ? ((~val) + W'(1)) : val;
  end

endmodule

// File: rtl/seq_mult_sm.sv
// Shift-add multiplier, signed or unsigned: done DW+2 cycles after start (fewer with early exit).
// One operation in flight; start is only taken while ready, clean aborts from any state.
module seq_mult_sm #(
  parameter int DW         = 8,
  parameter int EARLY_TERM = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clean,
  input  logic          signed_mode,
  input  logic [DW-1:0] multiplicand,
  input  logic [DW-1:0] multiplier,
  output logic          ready,
  output logic          done,
  output logic [2*DW-1:0] product,
  output logic          sign
);

  import seq_mult_sm_pkg::*;

  localparam int PW   = 2 * DW;
  localparam int CNTW = $clog2(DW);

  typedef logic [CNTW:0] cnt_t;

  state_t          state;
  ctrl_t           ctrl;

  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic            smode_q;
  logic [DW-1:0]   mag_a;
  logic [DW-1:0]   mag_b;
  logic            sgn_a;
  logic            sgn_b;

  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_nxt;
  logic [PW-1:0]   mltnd;
  logic [DW-1:0]   mlter;
  logic [DW-1:0]   mlter_nxt;
  cnt_t            cnt;
  logic            res_sign;
  logic            last_iter;

  logic [PW-1:0]   prod_nxt;
  logic            prod_neg;
  logic            sign_nxt;

  mag_sign_conv #(.W(DW)) u_mag_a (
    .val         (a_q),
    .signed_mode (smode_q),
    .neg_req     (1'b0),
    .mag         (mag_a),
    .sgn         (sgn_a)
  );

  mag_sign_conv #(.W(DW)) u_mag_b (
    .val         (b_q),
    .signed_mode (smode_q),
    .neg_req     (1'b0),
    .mag         (mag_b),
    .sgn         (sgn_b)
  );

  // Final sign application on the accumulator value produced by the last iteration.
  mag_sign_conv #(.W(PW)) u_prod (
    .val         (acc_nxt),
    .signed_mode (1'b0),
    .neg_req     (res_sign),
    .mag         (prod_nxt),
    .sgn         (prod_neg)
  );

  assign sign_nxt = prod_neg & (acc_nxt != '0);

  always_comb begin
    acc_nxt   = mlter[0] ? (acc + mltnd) : acc;
    mlter_nxt = mlter >> 1;
    last_iter = (cnt == cnt_t'(DW - 1)) || ((EARLY_TERM != 0) && (mlter_nxt == '0));

    ctrl       = '0;
    ctrl.state = state;
    ctrl.clean = clean;

    case (state)
      IDLE: begin
        ctrl.ready = 1'b1;
        if (start && !clean) begin
          ctrl.load  = 1'b1;
          ctrl.state = INIT;
        end
      end
      INIT:      ctrl.state = ADD_SHIFT;
      ADD_SHIFT: if (last_iter) ctrl.state = DONE;
      DONE: begin
        ctrl.done  = 1'b1;
        ctrl.state = IDLE;
      end
      default:   ctrl.state = IDLE;
    endcase

    if (clean) ctrl.state = IDLE;
  end

  assign ready = ctrl.ready;
  assign done  = ctrl.done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      smode_q  <= 1'b0;
      acc      <= '0;
      mltnd    <= '0;
      mlter    <= '0;
      cnt      <= '0;
      res_sign <= 1'b0;
      product  <= '0;
      sign     <= 1'b0;
    end else begin
      state <= ctrl.state;
      if (ctrl.clean) begin
        a_q      <= '0;
        b_q      <= '0;
        smode_q  <= 1'b0;
        acc      <= '0;
        mltnd    <= '0;
        mlter    <= '0;
        cnt      <= '0;
        res_sign <= 1'b0;
        product  <= '0;
        sign     <= 1'b0;
      end else begin
        if (ctrl.load) begin
          a_q     <= multiplicand;
          b_q     <= multiplier;
          smode_q <= signed_mode;
        end
        case (state)
          INIT: begin
            acc      <= '0;
            mltnd    <= {{DW{1'b0}}, mag_a};
            mlter    <= mag_b;
            cnt      <= '0;
            res_sign <= sgn_a ^ sgn_b;
          end
          ADD_SHIFT: begin
            acc   <= acc_nxt;
            mltnd <= mltnd << 1;
            mlter <= mlter_nxt;
            cnt   <= cnt + cnt_t'(1);
            // Result is registered on entry to DONE so it is valid while done is high.
            if (last_iter) begin
              product <= prod_nxt;
              sign    <= sign_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
